// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry and keyboard
// command bytes used by host logic.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_e;

    localparam int FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between game logic (master) and the PS/2
// transmitter (slave), plus the transmitter's status pulses.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output tx_done,
        output tx_error
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes the sensed ps2_clk/ps2_data lines, deglitches clk and flags
// filtered falling edges; shared with the receive path.
module ps2_line_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_filt,
    output logic data_sync,
    output logic clk_fall
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [CNT_W-1:0]       stable_cnt_q, stable_cnt_d;
    logic                   clk_filt_q, clk_filt_d;
    logic                   clk_fall_q, clk_fall_d;
    logic                   clk_synced;

    assign clk_synced = clk_sync_q[SYNC_STAGES-1];

    // NOTE: every signal gets its default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], data_in};
        stable_cnt_d = '0;
        clk_filt_d   = clk_filt_q;

        // The synced level must disagree for FILTER_CYCLES straight cycles.
        if (clk_synced != clk_filt_q) begin
            if (stable_cnt_q == FILTER_LAST) begin
                clk_filt_d = clk_synced;
            end else begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end
        end

        clk_fall_d = clk_filt_q & ~clk_filt_d;
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            stable_cnt_q <= '0;
            clk_filt_q   <= 1'b1;
            clk_fall_q   <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            stable_cnt_q <= stable_cnt_d;
            clk_filt_q   <= clk_filt_d;
            clk_fall_q   <= clk_fall_d;
        end
    end

    assign clk_filt  = clk_filt_q;
    assign data_sync = data_sync_q[SYNC_STAGES-1];
    assign clk_fall  = clk_fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked
// bit shifting and ACK check, exposed as open-drain pull controls.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_CYCLES  = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         clk_100mHz,
    input  logic         reset,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_pull,
    output logic         ps2_data_pull
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // bit_cnt_q = k means frame bit k has been driven; the next fall drives k+1.
    localparam logic [3:0] BIT_PARITY = 4'(FRAME_BITS - 3);
    localparam logic [3:0] BIT_STOP   = 4'(FRAME_BITS - 2);

    logic clk_filt;
    logic data_sync;
    logic clk_fall;

    ps2_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_line_filter (
        .clk       (clk_100mHz),
        .reset     (reset),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_filt  (clk_filt),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_pull_q, clk_pull_d;
    logic             data_pull_q, data_pull_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_error_q, tx_error_d;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        clk_pull_d  = clk_pull_q;
        data_pull_d = data_pull_q;
        tx_ready_d  = tx_ready_q;
        busy_d      = busy_q;
        tx_done_d   = 1'b0;
        tx_error_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (host.tx_valid && tx_ready_q) begin
                    shift_d     = host.tx_data;
                    parity_d    = odd_parity(host.tx_data);
                    cnt_d       = '0;
                    clk_pull_d  = 1'b1;
                    data_pull_d = 1'b0;
                    tx_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d       = '0;
                    clk_pull_d  = 1'b0;
                    data_pull_d = 1'b1;
                    state_d     = RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RTS: begin
                if (clk_fall) begin
                    data_pull_d = ~shift_q[0];
                    shift_d     = shift_q >> 1;
                    bit_cnt_d   = 4'd1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == BIT_STOP) begin
                        data_pull_d = 1'b0;
                        state_d     = ACK;
                    end else if (bit_cnt_q == BIT_PARITY) begin
                        data_pull_d = ~parity_q;
                    end else begin
                        data_pull_d = ~shift_q[0];
                        shift_d     = shift_q >> 1;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (!data_sync) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        tx_error_d = 1'b1;
                        tx_ready_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_sync) begin
                    tx_done_d  = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Device watchdog: any fall restarts it; expiry abandons the frame.
        if (state_q inside {RTS, SHIFT, ACK, WAIT_IDLE}) begin
            if (clk_fall) begin
                cnt_d = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
                clk_pull_d  = 1'b0;
                data_pull_d = 1'b0;
                tx_done_d   = 1'b0;
                tx_error_d  = 1'b1;
                tx_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mHz) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            clk_pull_q  <= 1'b0;
            data_pull_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            clk_pull_q  <= clk_pull_d;
            data_pull_q <= data_pull_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
            tx_error_q  <= tx_error_d;
        end
    end

    assign host.tx_ready = tx_ready_q;
    assign host.busy     = busy_q;
    assign host.tx_done  = tx_done_q;
    assign host.tx_error = tx_error_q;
    assign ps2_clk_pull  = clk_pull_q;
    assign ps2_data_pull = data_pull_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a keyboard model that clocks the
// frame, samples bits on its rising edges and ACKs or NACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT  = 1000;
    localparam int TIMEOUT  = 5000;
    localparam int FILTER   = 8;
    localparam int SYNC     = 2;
    localparam int HALF     = 40;
    // Device clock low -> tx_error: SYNC flops, FILTER stable cycles, then the FSM edge.
    localparam int NACK_LAT = SYNC + FILTER + 1;

    typedef struct {
        logic [7:0] data;
        logic       parity;
    } vec_t;

    logic clk_100mHz = 1'b0;
    logic reset      = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_pull, ps2_data_pull;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_CYCLES  (FILTER),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk_100mHz    (clk_100mHz),
        .reset         (reset),
        .host          (bus),
        .ps2_clk_in    (ps2_clk_in),
        .ps2_data_in   (ps2_data_in),
        .ps2_clk_pull  (ps2_clk_pull),
        .ps2_data_pull (ps2_data_pull)
    );

    always #5 clk_100mHz = ~clk_100mHz;

    assign ps2_clk_in  = ~(ps2_clk_pull | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_pull | dev_data_low);

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int viol     = 0;
    logic busy_prev = 1'b0;
    logic [10:0] exp_q[$];
    vec_t vecs[4];

    always @(negedge clk_100mHz) begin
        if (bus.tx_done) done_cnt++;
        if (bus.tx_error) err_cnt++;
        if (bus.tx_done && bus.tx_error) viol++;
        if (busy_prev && !bus.busy && !(bus.tx_done || bus.tx_error) && !reset) viol++;
        busy_prev = bus.busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic par, input bit push);
        @(negedge clk_100mHz);
        check("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk_100mHz);
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~d;
        check("busy_after_accept", bus.busy, 1);
        if (push) exp_q.push_back({1'b1, par, d, 1'b0});
    endtask

    task automatic wait_inhibit(output int n);
        n = 0;
        while (ps2_clk_pull && n < INHIBIT + 100) begin
            n++;
            @(negedge clk_100mHz);
        end
    endtask

    task automatic device(input int n_clk, input bit ack_low, input int glitch_bit,
                          output logic [10:0] got, output int err_lat, output logic busy_at_err);
        got         = '0;
        err_lat     = -1;
        busy_at_err = 1'b1;
        repeat (20) @(negedge clk_100mHz);
        got[0] = ps2_data_in;
        for (int i = 1; i <= n_clk; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk_100mHz);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk_100mHz);
            got[i] = ps2_data_in;
            if (i == glitch_bit) begin
                repeat (8) @(negedge clk_100mHz);
                dev_clk_low  = 1'b1;
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'hAA;
                repeat (3) @(negedge clk_100mHz);
                dev_clk_low  = 1'b0;
                bus.tx_valid = 1'b0;
                repeat (HALF - 13) @(negedge clk_100mHz);
            end else begin
                repeat (HALF - 2) @(negedge clk_100mHz);
            end
        end
        if (n_clk == 10) begin
            dev_data_low = ack_low;
            repeat (5) @(negedge clk_100mHz);
            dev_clk_low = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk_100mHz);
                if (bus.tx_error && err_lat < 0) begin
                    err_lat     = k;
                    busy_at_err = bus.busy;
                end
            end
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk_100mHz);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic compare_frame(input logic [10:0] got);
        logic [10:0] exp;
        check("scoreboard_has_entry", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("frame_bits", got, exp);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.tx_done && !bus.tx_error && n < 300) begin
            @(negedge clk_100mHz);
            n++;
        end
        check("tx_done_pulse", bus.tx_done, 1);
        check("ready_at_done", bus.tx_ready, 1);
        check("busy_falls_with_done", bus.busy, 0);
    endtask

    task automatic full_send(input logic [7:0] d, input logic par, input int glitch_bit);
        int n, lat, d0;
        logic [10:0] got;
        logic b;
        d0 = done_cnt;
        send(d, par, 1'b1);
        wait_inhibit(n);
        check("inhibit_len", n, INHIBIT);
        check("start_bit_pull", ps2_data_pull, 1);
        device(10, 1'b1, glitch_bit, got, lat, b);
        compare_frame(got);
        wait_done();
        repeat (5) @(negedge clk_100mHz);
        check("one_done_per_frame", done_cnt - d0, 1);
    endtask

    initial begin
        int n, lat, d0, e0;
        logic [10:0] got;
        logic b;

        vecs[0] = '{data: CMD_SET_LEDS, parity: 1'b1};
        vecs[1] = '{data: 8'h01,        parity: 1'b0};
        vecs[2] = '{data: 8'h00,        parity: 1'b1};
        vecs[3] = '{data: CMD_RESET,    parity: 1'b1};

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk_100mHz);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done_error", {bus.tx_done, bus.tx_error}, 0);
        check("rst_pulls", {ps2_clk_pull, ps2_data_pull}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk_100mHz);

        for (int i = 0; i < 4; i++) begin
            full_send(vecs[i].data, vecs[i].parity, -1);
        end

        // Device never clocks after RTS.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h5A, 1'b1, 1'b0);
        wait_inhibit(n);
        n = 0;
        while (!bus.tx_error && n < TIMEOUT + 100) begin
            @(negedge clk_100mHz);
            n++;
        end
        check("timeout_latency", n, TIMEOUT);
        check("timeout_pulls_released", {ps2_clk_pull, ps2_data_pull}, 0);
        check("timeout_busy", bus.busy, 0);
        repeat (5) @(negedge clk_100mHz);
        check("timeout_error_count", err_cnt - e0, 1);
        check("timeout_no_done", done_cnt - d0, 0);

        // Device leaves data high at the ACK clock.
        d0 = done_cnt;
        e0 = err_cnt;
        send(CMD_RESET, 1'b1, 1'b1);
        wait_inhibit(n);
        device(10, 1'b0, -1, got, lat, b);
        compare_frame(got);
        check("nack_error_latency", lat, NACK_LAT);
        check("nack_busy_falls_with_error", b, 0);
        repeat (20) @(negedge clk_100mHz);
        check("nack_error_count", err_cnt - e0, 1);
        check("nack_no_done", done_cnt - d0, 0);
        check("nack_ready", bus.tx_ready, 1);

        // Reset after four device clocks, then a clean send.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h00, 1'b1, 1'b0);
        wait_inhibit(n);
        device(4, 1'b1, -1, got, lat, b);
        check("shift_data_pulled", ps2_data_pull, 1);
        reset = 1'b1;
        @(negedge clk_100mHz);
        check("midreset_pulls", {ps2_clk_pull, ps2_data_pull}, 0);
        check("midreset_ready", bus.tx_ready, 1);
        @(negedge clk_100mHz);
        reset = 1'b0;
        repeat (20) @(negedge clk_100mHz);
        check("midreset_no_pulses", {done_cnt - d0, err_cnt - e0}, 0);
        full_send(CMD_ENABLE, 1'b0, -1);

        // Clock glitch plus a tx_valid pulse while busy.
        d0 = done_cnt;
        full_send(CMD_SET_LEDS, 1'b1, 5);
        n = 0;
        repeat (INHIBIT + 200) begin
            @(negedge clk_100mHz);
            if (ps2_clk_pull) n++;
        end
        check("no_second_frame", n, 0);
        check("glitch_single_done", done_cnt - d0, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        check("protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
